// File: rtl/dekatron_pkg.sv
// Shared constants and state encoding for the dekatron pulse decoder.
// The one-hot helper validates externally loaded positions.
package dekatron_pkg;

  localparam int DEK_POSITIONS = 10;

  localparam logic [DEK_POSITIONS-1:0] DEK_RESET_POS =
    10'b0000000001;

  typedef logic [2:0] dek_state_t;

  localparam dek_state_t S_IDLE   = 3'd0;
  localparam dek_state_t S_FWD_G1 = 3'd1;
  localparam dek_state_t S_FWD_G2 = 3'd2;
  localparam dek_state_t S_REV_G1 = 3'd3;
  localparam dek_state_t S_REV_G2 = 3'd4;
  localparam dek_state_t S_ERR    = 3'd5;

  function automatic logic dek_onehot(
    input logic [DEK_POSITIONS-1:0] v
  );
    logic [DEK_POSITIONS-1:0] dec;
    dec = v - {{(DEK_POSITIONS-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & dec) == '0);
  endfunction

endpackage

// File: rtl/dekatron_in_sync.sv
// Multi-flop synchronizer for one active-low guide input.
// Resets to 1 so a released guide is seen during and after reset.
module dekatron_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= STAGES'({ff, d});
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/dekatron_pulse_decoder.sv
// Decodes two-phase dekatron guide pulses into a one-hot position mirror
// with step, direction, carry/borrow strobes and a sticky error flag.
module dekatron_pulse_decoder
  import dekatron_pkg::*;
#(
  parameter int TIMEOUT     = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     PulseRight_n,
  input  logic                     PulseLeft_n,
  input  logic                     Set,
  input  logic [DEK_POSITIONS-1:0] In,
  input  logic                     ErrClr,
  output logic [DEK_POSITIONS-1:0] Pos,
  output logic                     Step,
  output logic                     Dir,
  output logic                     Carry,
  output logic                     Borrow,
  output logic                     Error,
  output logic                     Ready
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam int TOP = DEK_POSITIONS - 1;

  logic r_hi;
  logic l_hi;

  dekatron_in_sync #(.STAGES(SYNC_STAGES)) u_sync_r (
    .clk (Clk),
    .rst (Rst),
    .d   (PulseRight_n),
    .q   (r_hi)
  );

  dekatron_in_sync #(.STAGES(SYNC_STAGES)) u_sync_l (
    .clk (Clk),
    .rst (Rst),
    .d   (PulseLeft_n),
    .q   (l_hi)
  );

  dek_state_t    state;
  dek_state_t    state_nx;
  logic [CW-1:0] cnt;

  logic both_hi;
  logic both_lo;
  logic r_only;
  logic l_only;
  logic expired;
  logic fwd_done;
  logic rev_done;

  assign both_hi = r_hi & l_hi;
  assign both_lo = ~r_hi & ~l_hi;
  assign r_only  = ~r_hi & l_hi;
  assign l_only  = r_hi & ~l_hi;
  assign expired = (cnt == CW'(TIMEOUT));

  assign fwd_done = (state == S_FWD_G2) && both_hi;
  assign rev_done = (state == S_REV_G2) && both_hi;

  // Guide-sequence transitions; a stalled phase escalates to ERR.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (both_lo)     state_nx = S_ERR;
        else if (r_only) state_nx = S_FWD_G1;
        else if (l_only) state_nx = S_REV_G1;
      end
      S_FWD_G1: begin
        if (both_lo)      state_nx = S_ERR;
        else if (both_hi) state_nx = S_IDLE;
        else if (l_only)  state_nx = S_FWD_G2;
        else if (expired) state_nx = S_ERR;
      end
      S_FWD_G2: begin
        if (!r_hi)        state_nx = S_ERR;
        else if (both_hi) state_nx = S_IDLE;
        else if (expired) state_nx = S_ERR;
      end
      S_REV_G1: begin
        if (both_lo)      state_nx = S_ERR;
        else if (both_hi) state_nx = S_IDLE;
        else if (r_only)  state_nx = S_REV_G2;
        else if (expired) state_nx = S_ERR;
      end
      S_REV_G2: begin
        if (!l_hi)        state_nx = S_ERR;
        else if (both_hi) state_nx = S_IDLE;
        else if (expired) state_nx = S_ERR;
      end
      default: state_nx = S_ERR;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      Pos    <= DEK_RESET_POS;
      Step   <= 1'b0;
      Dir    <= 1'b0;
      Carry  <= 1'b0;
      Borrow <= 1'b0;
      Error  <= 1'b0;
    end else begin
      Step   <= 1'b0;
      Carry  <= 1'b0;
      Borrow <= 1'b0;
      if (Set) begin
        cnt <= '0;
        if (dek_onehot(In)) begin
          Pos   <= In;
          state <= S_IDLE;
        end else begin
          Pos   <= DEK_RESET_POS;
          Error <= 1'b1;
          state <= S_ERR;
        end
      end else if (ErrClr) begin
        cnt   <= '0;
        Error <= 1'b0;
        if (state == S_ERR && !both_hi) state <= S_ERR;
        else                            state <= S_IDLE;
      end else if (state == S_ERR) begin
        cnt <= '0;
        if (!Error && both_hi) state <= S_IDLE;
      end else begin
        state <= state_nx;
        if (state_nx != state || state == S_IDLE) cnt <= '0;
        else                                      cnt <= cnt + CW'(1);
        if (state_nx == S_ERR) Error <= 1'b1;
        if (fwd_done) begin
          Step  <= 1'b1;
          Dir   <= 1'b0;
          Pos   <= {Pos[TOP-1:0], Pos[TOP]};
          Carry <= Pos[TOP];
        end
        if (rev_done) begin
          Step   <= 1'b1;
          Dir    <= 1'b1;
          Pos    <= {Pos[0], Pos[TOP:1]};
          Borrow <= Pos[0];
        end
      end
    end
  end

  assign Ready = (state == S_IDLE) && both_hi && !Error;

endmodule

// File: tb/tb_dekatron_pulse_decoder.sv
// Scoreboard bench for dekatron_pulse_decoder: expected steps are queued
// as guide sequences are driven and matched against each Step strobe.
module tb_dekatron_pulse_decoder;

  logic       clk;
  logic       rst;
  logic       right_n;
  logic       left_n;
  logic       set;
  logic [9:0] in_val;
  logic       err_clr;
  logic [9:0] pos;
  logic       step;
  logic       dir;
  logic       carry;
  logic       borrow;
  logic       error;
  logic       ready;

  dekatron_pulse_decoder #(
    .TIMEOUT     (15),
    .SYNC_STAGES (2)
  ) dut (
    .Clk          (clk),
    .Rst          (rst),
    .PulseRight_n (right_n),
    .PulseLeft_n  (left_n),
    .Set          (set),
    .In           (in_val),
    .ErrClr       (err_clr),
    .Pos          (pos),
    .Step         (step),
    .Dir          (dir),
    .Carry        (carry),
    .Borrow       (borrow),
    .Error        (error),
    .Ready        (ready)
  );

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       carry;
    logic       borrow;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_steps  = 0;
  int   cb_cyc   = 0;
  int   exp_cb   = 0;
  logic [9:0] mpos;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (carry || borrow) cb_cyc++;
      if (step) begin
        exp_t e;
        n_steps++;
        if (sb.size() == 0) begin
          check("unexpected_step", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("step_pos", 32'(pos), 32'(e.pos));
          check("step_dir", 32'(dir), 32'(e.dir));
          check("step_carry", 32'(carry), 32'(e.carry));
          check("step_borrow", 32'(borrow), 32'(e.borrow));
        end
      end
    end
  end

  task automatic fwd_step(input int ph);
    exp_t e;
    e.pos    = {mpos[8:0], mpos[9]};
    e.dir    = 1'b0;
    e.carry  = mpos[9];
    e.borrow = 1'b0;
    mpos = e.pos;
    if (e.carry) exp_cb++;
    sb.push_back(e);
    right_n = 1'b0;
    tick(ph);
    right_n = 1'b1;
    left_n  = 1'b0;
    tick(ph);
    left_n = 1'b1;
    tick(5);
  endtask

  task automatic rev_step(input int ph);
    exp_t e;
    e.pos    = {mpos[0], mpos[9:1]};
    e.dir    = 1'b1;
    e.carry  = 1'b0;
    e.borrow = mpos[0];
    mpos = e.pos;
    if (e.borrow) exp_cb++;
    sb.push_back(e);
    left_n = 1'b0;
    tick(ph);
    left_n  = 1'b1;
    right_n = 1'b0;
    tick(ph);
    right_n = 1'b1;
    tick(5);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int c0;
    rst     = 1'b1;
    right_n = 1'b1;
    left_n  = 1'b1;
    set     = 1'b0;
    in_val  = '0;
    err_clr = 1'b0;
    mpos    = 10'b0000000001;
    tick(3);
    check("rst_pos", 32'(pos), 32'(10'b1));
    check("rst_step", 32'(step), 32'(0));
    check("rst_dir", 32'(dir), 32'(0));
    check("rst_err", 32'(error), 32'(0));
    check("rst_carry", 32'(carry | borrow), 32'(0));
    rst = 1'b0;
    tick(2);
    check("rst_ready", 32'(ready), 32'(1));

    // three forward steps with 2-cycle phases
    s0 = n_steps;
    repeat (3) fwd_step(2);
    check("fwd3_steps", 32'(n_steps - s0), 32'(3));
    check("fwd3_pos", 32'(pos), 32'(10'b0000001000));
    check("fwd3_dir", 32'(dir), 32'(0));

    // wrap through 9 -> 0 and back
    set    = 1'b1;
    in_val = 10'b1000000000;
    tick(1);
    set  = 1'b0;
    mpos = 10'b1000000000;
    check("set9_pos", 32'(pos), 32'(10'b1000000000));
    c0 = cb_cyc;
    fwd_step(2);
    check("carry_cycles", 32'(cb_cyc - c0), 32'(1));
    check("wrap_fwd_pos", 32'(pos), 32'(10'b1));
    c0 = cb_cyc;
    rev_step(3);
    check("borrow_cycles", 32'(cb_cyc - c0), 32'(1));
    check("wrap_rev_pos", 32'(pos), 32'(10'b1000000000));
    check("wrap_rev_dir", 32'(dir), 32'(1));
    rev_step(2);
    check("rev_pos", 32'(pos), 32'(10'b0100000000));

    // both guides low from idle
    right_n = 1'b0;
    left_n  = 1'b0;
    tick(1);
    right_n = 1'b1;
    left_n  = 1'b1;
    tick(5);
    check("bothlo_err", 32'(error), 32'(1));
    check("bothlo_ready", 32'(ready), 32'(0));
    check("bothlo_pos", 32'(pos), 32'(mpos));
    pulse_clr();
    check("clr_err", 32'(error), 32'(0));
    check("clr_ready", 32'(ready), 32'(1));

    // Right held low: phase entered 3 edges after drive, limit after 16 cycles
    right_n = 1'b0;
    tick(18);
    check("to_early", 32'(error), 32'(0));
    tick(1);
    check("to_err", 32'(error), 32'(1));
    pulse_clr();
    check("clr_low_err", 32'(error), 32'(0));
    check("clr_low_ready", 32'(ready), 32'(0));
    right_n = 1'b1;
    tick(5);
    check("clr_low_ready2", 32'(ready), 32'(1));
    check("to_pos", 32'(pos), 32'(mpos));

    // Set during the completion cycle of a forward step
    right_n = 1'b0;
    tick(2);
    right_n = 1'b1;
    left_n  = 1'b0;
    tick(2);
    left_n = 1'b1;
    tick(2);
    set    = 1'b1;
    in_val = 10'b0001000000;
    tick(1);
    set  = 1'b0;
    mpos = 10'b0001000000;
    tick(4);
    check("setwin_pos", 32'(pos), 32'(10'b0001000000));
    check("setwin_err", 32'(error), 32'(0));
    set    = 1'b1;
    in_val = 10'b0000000011;
    tick(1);
    set  = 1'b0;
    mpos = 10'b1;
    check("setbad_pos", 32'(pos), 32'(10'b1));
    check("setbad_err", 32'(error), 32'(1));
    tick(2);
    pulse_clr();
    check("setbad_clr", 32'(ready), 32'(1));

    // reset while in the second forward phase
    fwd_step(2);
    check("pre_rst_pos", 32'(pos), 32'(10'b10));
    right_n = 1'b0;
    tick(2);
    right_n = 1'b1;
    left_n  = 1'b0;
    tick(4);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pos", 32'(pos), 32'(10'b1));
    left_n = 1'b1;
    mpos   = 10'b1;
    tick(2);
    rst = 1'b0;
    s0  = n_steps;
    tick(6);
    check("post_rst_nostep", 32'(n_steps - s0), 32'(0));
    rev_step(2);
    check("post_rst_pos", 32'(pos), 32'(10'b1000000000));

    tick(3);
    check("sb_empty", 32'(sb.size()), 32'(0));
    check("cb_total", 32'(cb_cyc), 32'(exp_cb));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
